// File: rtl/net_wrapper.sv
// XOR classifier: 2-2-2 fixed-weight ReLU net in Q4.4, one MAC per clock; done rises 15 edges after btn[0] release.
// btn[0] restarts or aborts at any time; optional busy LED on led[3] under NET_BUSY_LED_EN.
module net_wrapper #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic [3:0] btn,
    output logic [3:0] led
);
    localparam int ACC_W  = 2*DATA_W + 2;
    localparam int PROD_W = 2*DATA_W;
    localparam int ONE_I  = 1 << FRAC_W;

    localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(ONE_I);
    localparam logic signed [DATA_W-1:0] NEG_ONE = DATA_W'(-ONE_I);
    localparam logic signed [DATA_W-1:0] TWO     = DATA_W'(2*ONE_I);
    localparam logic signed [DATA_W-1:0] NEG_TWO = DATA_W'(-2*ONE_I);
    localparam logic signed [DATA_W-1:0] HALF    = DATA_W'(ONE_I/2);
    localparam logic signed [ACC_W-1:0]  ACT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HID, OUT, ARGMAX, DONE} state_t;

    state_t                     state, state_nxt;
    logic [1:0]                 term;
    logic                       neuron;
    logic signed [DATA_W-1:0]   x0, x1, h0, h1;
    logic signed [ACC_W-1:0]    acc, o0, o1;
    logic [1:0]                 cls;
    logic                       done;

    logic                       start, last_term, layer;
    logic signed [DATA_W-1:0]   coef, operand, act;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc_nxt, shifted;
    logic                       unused_inputs;

    assign start         = btn[0];
    assign last_term     = (term == 2'd2);
    assign layer         = (state == OUT);
    assign unused_inputs = ^{sw[3:2], btn[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (!start) state_nxt = HID;
            HID:     if (start) state_nxt = LOAD;
                     else if (last_term && neuron) state_nxt = OUT;
            OUT:     if (start) state_nxt = LOAD;
                     else if (last_term && neuron) state_nxt = ARGMAX;
            ARGMAX:  state_nxt = start ? LOAD : DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Coefficient ROM indexed by {layer, neuron, term}; term 0 is the bias.
    always_comb begin
        coef = '0;
        case ({layer, neuron, term})
            4'b0_0_01, 4'b0_0_10: coef = ONE;
            4'b0_1_00:            coef = NEG_ONE;
            4'b0_1_01, 4'b0_1_10: coef = ONE;
            4'b1_0_00:            coef = HALF;
            4'b1_0_01:            coef = NEG_ONE;
            4'b1_0_10:            coef = TWO;
            4'b1_1_01:            coef = ONE;
            4'b1_1_10:            coef = NEG_TWO;
            default:              coef = '0;
        endcase
    end

    always_comb begin
        operand = '0;
        if (term == 2'd1) operand = layer ? h0 : x0;
        else              operand = layer ? h1 : x1;
        prod    = coef * operand;
        acc_nxt = (term == 2'd0) ? (ACC_W'(coef) <<< FRAC_W) : (acc + ACC_W'(prod));
        shifted = acc_nxt >>> FRAC_W;
        if (shifted < 0)            act = '0;
        else if (shifted > ACT_MAX) act = ACT_MAX[DATA_W-1:0];
        else                        act = shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term   <= '0;
            neuron <= 1'b0;
            x0     <= '0;
            x1     <= '0;
            h0     <= '0;
            h1     <= '0;
            acc    <= '0;
            o0     <= '0;
            o1     <= '0;
            cls    <= '0;
            done   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    x0     <= sw[0] ? ONE : '0;
                    x1     <= sw[1] ? ONE : '0;
                    term   <= '0;
                    neuron <= 1'b0;
                    acc    <= '0;
                end
                HID, OUT: begin
                    if (!start) begin
                        acc <= acc_nxt;
                        if (last_term) begin
                            term   <= '0;
                            neuron <= ~neuron;
                            if (!layer && !neuron) h0 <= act;
                            if (!layer &&  neuron) h1 <= act;
                            if ( layer && !neuron) o0 <= acc_nxt;
                            if ( layer &&  neuron) o1 <= acc_nxt;
                        end else begin
                            term <= term + 2'd1;
                        end
                    end
                end
                // Ties fall to class 0, so exactly one class LED is lit.
                ARGMAX: if (!start) cls <= (o1 > o0) ? 2'b10 : 2'b01;
                DONE:   if (!start) done <= 1'b1;
                default: ;
            endcase
            if (state_nxt == LOAD || state == LOAD) begin
                cls  <= '0;
                done <= 1'b0;
            end
        end
    end

    assign led[2:0] = {done, cls};
`ifdef NET_BUSY_LED_EN
    assign led[3] = (state == HID) || (state == OUT) || (state == ARGMAX);
`else
    assign led[3] = 1'b0;
`endif

endmodule

// File: tb/tb_net_wrapper.sv
// Directed bench for net_wrapper: XOR truth table, latency, hold, abort and reset behaviour.
module tb_net_wrapper;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw    = 4'b0000;
    logic [3:0] btn   = 4'b0000;
    logic [3:0] led;
    int n_cmp = 0;
    int n_bad = 0;

`ifdef NET_BUSY_LED_EN
    localparam int BUSY_EXP = 13;
`else
    localparam int BUSY_EXP = 0;
`endif

    always #5 clk = ~clk;

    net_wrapper dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .btn   (btn),
        .led   (led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [1:0] s, input int cycles);
        @(negedge clk);
        sw  = {2'b00, s};
        btn = 4'b0001;
        repeat (cycles) @(negedge clk);
    endtask

    // Releases btn[0] at a negedge; edge 1 is the first edge that samples it low.
    task automatic measure(input string tag, input logic [1:0] exp_cls);
        int         busy;
        logic [3:0] l14;
        busy = 0;
        l14  = '0;
        btn  = 4'b0000;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            if (led[3]) busy++;
            if (e == 14) l14 = led;
        end
        check({tag, "_e14_done"}, 32'(l14[2]), 32'd0);
        check({tag, "_e14_cls"},  32'(l14[1:0]), 32'(exp_cls));
        check({tag, "_e15_done"}, 32'(led[2]), 32'd1);
        check({tag, "_e15_cls"},  32'(led[1:0]), 32'(exp_cls));
        check({tag, "_onehot"},   32'($countones(led[1:0])), 32'd1);
        check({tag, "_busy"},     32'(busy), 32'(BUSY_EXP));
    endtask

    initial begin
        #2;
        check("reset_led", 32'(led), 32'd0);
        #20 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_led", 32'(led), 32'd0);

        press(2'b10, 5); measure("sw10", 2'b10);
        press(2'b00, 5); measure("sw00", 2'b01);
        press(2'b11, 5); measure("sw11", 2'b01);
        press(2'b01, 5); measure("sw01", 2'b10);

        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            sw = 4'(s);
            @(posedge clk);
            #1;
            check("done_hold", 32'(led), 32'h6);
        end

        @(negedge clk);
        btn = 4'b0001;
        @(posedge clk);
        #1;
        check("done_to_load", 32'(led), 32'd0);

        // Abort: edge 6 of the computation samples btn[0] high.
        @(negedge clk);
        sw  = 4'b0000;
        btn = 4'b0000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        btn = 4'b0001;
        @(posedge clk);
        #1;
        check("abort_led", 32'(led), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_hold", 32'(led), 32'd0);
        press(2'b11, 3); measure("abort_sw11", 2'b01);

        // Reset in the middle of an evaluation.
        press(2'b01, 2);
        btn = 4'b0000;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("rst_mid", 32'(led), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_idle", 32'(led), 32'd0);

        // Reset while a result is displayed.
        press(2'b10, 2); measure("sw10_again", 2'b10);
        #2 rst_n = 1'b0;
        #1 check("rst_done", 32'(led), 32'd0);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_done_idle", 32'(led), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
